// File: rtl/tinker_mem_pkg.sv
// Shared types and helpers for the tinker data memory.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        B1 = 2'd0,
        B2 = 2'd1,
        B4 = 2'd2,
        B8 = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    function automatic logic [3:0] nbytes(input size_e size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-wide storage with one masked 64-bit write port and asynchronous
// 64-bit data and 32-bit fetch read ports.
module mem_byte_array #(
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              we,
    input  logic [7:0]        wmask,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [63:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [63:0]       rdata,
    input  logic [ADDR_W-1:0] faddr,
    output logic [31:0]       fdata
);

    localparam int MEM_BYTES = 2 ** ADDR_W;

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            if (wmask[0]) mem[waddr]                <= wdata[7:0];
            if (wmask[1]) mem[waddr + ADDR_W'(1)]   <= wdata[15:8];
            if (wmask[2]) mem[waddr + ADDR_W'(2)]   <= wdata[23:16];
            if (wmask[3]) mem[waddr + ADDR_W'(3)]   <= wdata[31:24];
            if (wmask[4]) mem[waddr + ADDR_W'(4)]   <= wdata[39:32];
            if (wmask[5]) mem[waddr + ADDR_W'(5)]   <= wdata[47:40];
            if (wmask[6]) mem[waddr + ADDR_W'(6)]   <= wdata[55:48];
            if (wmask[7]) mem[waddr + ADDR_W'(7)]   <= wdata[63:56];
        end
    end

    // Reads wrap at the top of the array; the parent discards any such bytes.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[raddr + ADDR_W'(i)];
        end
    end

    always_comb begin
        fdata = '0;
        for (int i = 0; i < 4; i++) begin
            fdata[8*i +: 8] = mem[faddr + ADDR_W'(i)];
        end
    end

endmodule

// File: rtl/tinker_data_mem.sv
// Byte-addressed little-endian memory: combinational fetch port plus a
// single-outstanding request/response data port with configurable latency.
module tinker_data_mem
    import tinker_mem_pkg::*;
#(
    parameter int ADDR_W  = 19,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ifetch_addr,
    output logic [31:0] ifetch_data,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [64:0] MEM_BYTES = 65'd1 << ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);

    mem_state_e  state;
    mem_state_e  next_state;
    logic [3:0]  count;

    logic        lat_we;
    size_e       lat_size;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;

    logic        accept;
    logic        commit;
    logic        op_we;
    size_e       op_size;
    logic [63:0] op_addr;
    logic [63:0] op_wdata;
    logic [3:0]  op_nbytes;
    logic        op_err;
    logic [7:0]  byte_mask;
    logic [63:0] array_rdata;
    logic [63:0] load_data;
    logic [31:0] array_fdata;
    logic        fetch_oob;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid) next_state = (LATENCY > 1) ? WAIT : RESP;
            WAIT:    if (count == 4'd1) next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign accept = (state == IDLE) && req_valid;
    assign commit = (next_state == RESP) && (state != RESP);

    // With LATENCY=1 the commit edge is the acceptance edge, so operands come straight from the request.
    assign op_we    = (state == IDLE) ? req_we            : lat_we;
    assign op_size  = (state == IDLE) ? size_e'(req_size) : lat_size;
    assign op_addr  = (state == IDLE) ? req_addr          : lat_addr;
    assign op_wdata = (state == IDLE) ? req_wdata         : lat_wdata;

    assign op_nbytes = nbytes(op_size);
    assign op_err    = ({1'b0, op_addr} + 65'(op_nbytes)) > MEM_BYTES;

    always_comb begin
        byte_mask = '0;
        load_data = '0;
        for (int i = 0; i < 8; i++) begin
            byte_mask[i]        = 4'(i) < op_nbytes;
            load_data[8*i +: 8] = byte_mask[i] ? array_rdata[8*i +: 8] : 8'h00;
        end
    end

    mem_byte_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && op_we && !op_err),
        .wmask (byte_mask),
        .waddr (op_addr[ADDR_W-1:0]),
        .wdata (op_wdata),
        .raddr (op_addr[ADDR_W-1:0]),
        .rdata (array_rdata),
        .faddr (ifetch_addr[ADDR_W-1:0]),
        .fdata (array_fdata)
    );

    assign fetch_oob   = ({1'b0, ifetch_addr} + 65'd4) > MEM_BYTES;
    assign ifetch_data = fetch_oob ? 32'h0 : array_fdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= 4'd0;
            lat_we     <= 1'b0;
            lat_size   <= B1;
            lat_addr   <= 64'h0;
            lat_wdata  <= 64'h0;
            resp_rdata <= 64'h0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                count     <= WAIT_LOAD;
                lat_we    <= req_we;
                lat_size  <= size_e'(req_size);
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                resp_err   <= op_err;
                resp_rdata <= (op_err || op_we) ? 64'h0 : load_data;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

endmodule

// File: tb/tb_tinker_data_mem.sv
// Self-checking bench for tinker_data_mem: a vector table on a LATENCY=2 instance
// plus hand sequences for reset, backpressure, fetch visibility and LATENCY 1/15.
module tb_tinker_data_mem;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    localparam int NVEC = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ifetch_addr;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;
    int          sel;

    logic [2:0]  rv;
    logic [2:0]  rr;
    logic [2:0]  rsv;
    logic [2:0]  rer;
    logic [31:0] fd  [3];
    logic [63:0] rd  [3];

    logic        obs_req_ready;
    logic        obs_resp_valid;
    logic        obs_resp_err;
    logic [63:0] obs_resp_rdata;
    logic [31:0] obs_ifetch;

    int lat_of [3] = '{2, 1, 15};
    int n_tests = 0;
    int n_fail  = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    assign rv[0] = req_valid && (sel == 0);
    assign rv[1] = req_valid && (sel == 1);
    assign rv[2] = req_valid && (sel == 2);

    always_comb begin
        obs_req_ready  = rr[0];
        obs_resp_valid = rsv[0];
        obs_resp_err   = rer[0];
        obs_resp_rdata = rd[0];
        obs_ifetch     = fd[0];
        case (sel)
            1: begin
                obs_req_ready  = rr[1];
                obs_resp_valid = rsv[1];
                obs_resp_err   = rer[1];
                obs_resp_rdata = rd[1];
                obs_ifetch     = fd[1];
            end
            2: begin
                obs_req_ready  = rr[2];
                obs_resp_valid = rsv[2];
                obs_resp_err   = rer[2];
                obs_resp_rdata = rd[2];
                obs_ifetch     = fd[2];
            end
            default: ;
        endcase
    end

    tinker_data_mem #(.ADDR_W(19), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .ifetch_addr(ifetch_addr), .ifetch_data(fd[0]),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsv[0]),
        .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_err(rer[0])
    );

    tinker_data_mem #(.ADDR_W(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .ifetch_addr(ifetch_addr), .ifetch_data(fd[1]),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsv[1]),
        .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_err(rer[1])
    );

    tinker_data_mem #(.ADDR_W(16), .LATENCY(15)) dut_l15 (
        .clk(clk), .reset(reset), .ifetch_addr(ifetch_addr), .ifetch_data(fd[2]),
        .req_valid(rv[2]), .req_ready(rr[2]), .req_we(req_we), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsv[2]),
        .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_err(rer[2])
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Presents one request in the current cycle and returns once resp_valid is seen.
    task automatic apply_stimulus(input int s, input logic we, input logic [1:0] size,
                                  input logic [63:0] addr, input logic [63:0] wdata,
                                  input string name, output logic [63:0] rdata, output logic err);
        int lat;
        sel       = s;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        lat       = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            req_valid = 1'b0;
            req_we    = ~we;
            req_size  = ~size;
            req_addr  = ~addr;
            req_wdata = ~wdata;
        end while (!obs_resp_valid && lat < 40);
        check_output({name, "_lat"}, 64'(lat), 64'(lat_of[s]));
        rdata = obs_resp_rdata;
        err   = obs_resp_err;
    endtask

    task automatic finish_response(input string name);
        @(posedge clk); #1;
        check_output({name, "_done"}, {62'h0, obs_resp_valid, obs_req_ready}, 64'h1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rdata;
        logic        err;
        logic [63:0] exp;

        vecs[0]  = '{1'b1, 2'd3, 64'h2000, 64'h1122334455667788, 64'h0, 1'b0, "st8_2000"};
        vecs[1]  = '{1'b0, 2'd2, 64'h2002, 64'hA5A5A5A5A5A5A5A5, 64'h33445566, 1'b0, "ld4_2002"};
        vecs[2]  = '{1'b0, 2'd3, 64'h2000, 64'h0, 64'h1122334455667788, 1'b0, "ld8_2000"};
        vecs[3]  = '{1'b0, 2'd0, 64'h2007, 64'h0, 64'h11, 1'b0, "ld1_2007"};
        vecs[4]  = '{1'b1, 2'd1, 64'h2001, 64'hFFFFFFFFFFFFBEEF, 64'h0, 1'b0, "st2_2001"};
        vecs[5]  = '{1'b0, 2'd3, 64'h2000, 64'h0, 64'h1122334455BEEF88, 1'b0, "ld8_2000b"};
        vecs[6]  = '{1'b0, 2'd1, 64'h2005, 64'h0, 64'h2233, 1'b0, "ld2_2005"};
        vecs[7]  = '{1'b1, 2'd2, 64'h7FFFC, 64'h12345678CAFEF00D, 64'h0, 1'b0, "st4_top"};
        vecs[8]  = '{1'b1, 2'd3, 64'h7FFFC, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, "st8_top_err"};
        vecs[9]  = '{1'b0, 2'd2, 64'h7FFFC, 64'h0, 64'hCAFEF00D, 1'b0, "ld4_top"};
        vecs[10] = '{1'b0, 2'd0, 64'h7FFFF, 64'h0, 64'hCA, 1'b0, "ld1_last"};
        vecs[11] = '{1'b0, 2'd1, 64'h7FFFF, 64'h0, 64'h0, 1'b1, "ld2_last_err"};
        vecs[12] = '{1'b0, 2'd3, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1, "ld8_wrap_err"};
        vecs[13] = '{1'b0, 2'd0, 64'h80000, 64'h0, 64'h0, 1'b1, "ld1_oob"};
        vecs[14] = '{1'b1, 2'd3, 64'h3000, 64'h0, 64'h0, 1'b0, "st8_3000_zero"};

        sel         = 0;
        reset       = 1'b0;
        resp_ready  = 1'b1;
        ifetch_addr = 64'h0;
        req_we      = 1'b1;
        req_size    = 2'd3;
        req_addr    = 64'h5000;
        req_wdata   = 64'hDEADBEEFDEADBEEF;
        req_valid   = 1'b1;

        // A request held during reset must never be taken.
        repeat (3) begin
            @(posedge clk); #1;
            check_output("rst_ready", {63'h0, obs_req_ready}, 64'h1);
            check_output("rst_valid", {62'h0, obs_resp_valid, obs_resp_err}, 64'h0);
            check_output("rst_rdata", obs_resp_rdata, 64'h0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            apply_stimulus(0, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                           vecs[i].name, rdata, err);
            check_output({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            check_output({vecs[i].name, "_err"}, 64'(err), 64'(vecs[i].exp_err));
            finish_response(vecs[i].name);
        end

        // A byte store becomes visible on the fetch port only after its commit edge.
        ifetch_addr = 64'h3000;
        sel         = 0;
        req_we      = 1'b1;
        req_size    = 2'd0;
        req_addr    = 64'h3001;
        req_wdata   = 64'h00000000000000AB;
        req_valid   = 1'b1;
        check_output("fetch_pre_accept", 64'(obs_ifetch), 64'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("fetch_pre_commit", 64'(obs_ifetch), 64'h0);
        check_output("fetch_wait_state", {63'h0, obs_resp_valid}, 64'h0);
        @(posedge clk); #1;
        check_output("fetch_resp_valid", {63'h0, obs_resp_valid}, 64'h1);
        check_output("fetch_post_commit", 64'(obs_ifetch), 64'h0000AB00);
        finish_response("st1_3001");
        apply_stimulus(0, 1'b0, 2'd3, 64'h3000, 64'h0, "ld8_3000", rdata, err);
        check_output("ld8_3000_rdata", rdata, 64'h000000000000AB00);
        finish_response("ld8_3000");
        ifetch_addr = 64'h7FFFC;
        #1 check_output("fetch_top", 64'(obs_ifetch), 64'hCAFEF00D);
        ifetch_addr = 64'h7FFFD;
        #1 check_output("fetch_oob", 64'(obs_ifetch), 64'h0);

        // Backpressure: the response must hold while resp_ready is low.
        resp_ready = 1'b0;
        apply_stimulus(0, 1'b0, 2'd2, 64'h2004, 64'h0, "bp_ld4", rdata, err);
        check_output("bp_first_rdata", rdata, 64'h11223344);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_output("bp_hold_valid", {62'h0, obs_resp_valid, obs_req_ready}, 64'h2);
            check_output("bp_hold_rdata", obs_resp_rdata, 64'h11223344);
        end
        resp_ready = 1'b1;
        #1 check_output("bp_release_same", {63'h0, obs_req_ready}, 64'h0);
        finish_response("bp_release");

        // Reset while a store is in flight; with LATENCY=1 it has already committed.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(k, 1'b1, 2'd3, 64'h4000, 64'h0123456789ABCDEF, "rst_preload", rdata, err);
            check_output("rst_preload_err", 64'(err), 64'h0);
            finish_response("rst_preload");
            sel       = k;
            req_we    = 1'b1;
            req_size  = 2'd3;
            req_addr  = 64'h4000;
            req_wdata = 64'hDEADDEADDEADDEAD;
            req_valid = 1'b1;
            @(posedge clk); #1;
            req_valid = 1'b0;
            if (k == 2) repeat (5) begin @(posedge clk); #1; end
            reset = 1'b0;
            #1;
            check_output("rst_mid_state", {62'h0, obs_req_ready, obs_resp_valid}, 64'h2);
            check_output("rst_mid_rdata", obs_resp_rdata, 64'h0);
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            exp = (k == 1) ? 64'hDEADDEADDEADDEAD : 64'h0123456789ABCDEF;
            apply_stimulus(k, 1'b0, 2'd3, 64'h4000, 64'h0, "rst_reload", rdata, err);
            check_output("rst_reload_rdata", rdata, exp);
            finish_response("rst_reload");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tinker_data_mem.md
# tinker_data_mem

Parametrised, byte-addressed, little-endian memory for the tinker core, replacing the fixed 512 KiB single-cycle memory. It provides a combinational 32-bit instruction-fetch port and a request/response data port. The data port supports configurable access latency, 1/2/4/8-byte accesses and out-of-range error reporting. It sits between the core's memory handler (load/store/call/return traffic) and the fetch unit.

## Interface
Parameters:
- `ADDR_W`, default 19: log2 of memory size in bytes; `MEM_BYTES = 2**ADDR_W`.
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`; legal range is 1..15.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low (asserted at 0); deassertion is synchronised externally.
- `ifetch_addr`  input  64  instruction byte address.
- `ifetch_data`  output  32  little-endian word at `ifetch_addr`; combinational.
- `req_valid`  input  1  data request present.
- `req_ready`  output  1  block can accept a request.
- `req_we`  input  1  1 = store, 0 = load.
- `req_size`  input  2  access size code: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes.
- `req_addr`  input  64  byte address.
- `req_wdata`  input  64  store data; low-order bytes are used.
- `resp_valid`  output  1  response available.
- `resp_ready`  input  1  consumer takes the response.
- `resp_rdata`  output  64  load data, zero-extended; 0 for stores and errors.
- `resp_err`  output  1  the access exceeded memory bounds.

## Operation
- The data port has one outstanding request. FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `req_ready` = 1.
  - A request is accepted on the edge where `req_valid && req_ready`.
  - On acceptance, `req_we`, `req_size`, `req_addr` and `req_wdata` are latched.
  - The next state is WAIT if `LATENCY > 1`, otherwise RESP.
- **WAIT**
  - A 4-bit counter, loaded with `LATENCY-1`, decrements each cycle.
  - The state leaves for RESP on the edge where the counter reaches 1.
- **Commit edge**: the edge that enters RESP.
  - Bounds check: error if `addr + nbytes > MEM_BYTES`, with `nbytes = 1 << size`, evaluated in 65-bit arithmetic so no wrap-around occurs.
  - Store with no error: bytes `addr .. addr+nbytes-1` ← `wdata[8*nbytes-1:0]`, little-endian.
  - Load with no error: `resp_rdata` ← bytes `addr..addr+nbytes-1`, zero-extended.
  - Error: no memory change; `resp_rdata` = 0 and `resp_err` = 1.
- **RESP**
  - `resp_valid` = 1. `resp_rdata` and `resp_err` are held stable.
  - The block returns to IDLE on the edge where `resp_ready` = 1.
  - `req_ready` = 0 in RESP, so there is no back-to-back overlap; throughput is at most 1 request per `LATENCY+1` cycles.
- **Fetch port**
  - `ifetch_data` = bytes `ifetch_addr..ifetch_addr+3`.
  - It returns 0 if `ifetch_addr + 4 > MEM_BYTES`.
  - A store committing on edge N becomes visible on `ifetch_data` after edge N. Before edge N the old data is shown.
- Misaligned accesses are legal.

## Timing
- **Reset asserted**
  - State is forced to IDLE and the counter to 0.
  - `req_ready` = 1; `resp_valid`, `resp_err` and `resp_rdata` are all 0.
  - Memory contents are not reset; the bench preloads the array before releasing reset.
- **Reset mid-operation**: a request in WAIT is discarded and its store is never committed. A store already committed stays in memory.
- **Latency**: request accepted on edge A → `resp_valid` high after edge A+LATENCY.
- `resp_ready` held at 1 → `resp_valid` lasts exactly one cycle and `req_ready` returns in the following cycle.
- `req_valid` while `req_ready` = 0 is ignored; the requester must hold it.
- `req_*` inputs may change freely after acceptance.

## Structure
- Package `tinker_mem_pkg` holds:
  - the `size_e` enum (B1, B2, B4, B8);
  - the `mem_state_e` enum (IDLE, WAIT, RESP);
  - the `nbytes()` function.
- Sub-module `mem_byte_array` holds the storage:
  - one write port with an 8-bit byte-enable mask (64-bit data);
  - two asynchronous read ports, one 64-bit and one 32-bit;
  - out-of-range behaviour is handled by the parent.
- The FSM, counter, bounds check and response registers stay in `tinker_data_mem`.

## Test plan
- Reset low with `req_valid` = 1 → `req_ready` = 1, `resp_valid` = 0; no acceptance until reset = 1.
- `LATENCY`=2: store size 3, addr 0x2000, data 0x1122334455667788 → `resp_valid` 2 cycles after acceptance, `resp_err` = 0. Then a size-2 load at 0x2002 → `resp_rdata` 0x0000000033445566.
- Size-0 store 0xAB to 0x3001, then a size-3 load at 0x3000 → only byte 1 changed. `ifetch_data` at 0x3000 shows 0x0000AB00 only after the commit edge.
- Size-3 store at `MEM_BYTES-4` → `resp_err` = 1, memory unchanged; a size-2 load at `MEM_BYTES-4` → `resp_err` = 0.
- `resp_ready` held 0 for 5 cycles → `resp_valid`/`resp_rdata` stable and `req_ready` = 0 throughout; `req_ready` returns one cycle after `resp_ready` = 1.
- Reset asserted during WAIT of a store to 0x4000 → store lost; after release, a load of 0x4000 returns the preloaded value. Repeat with `LATENCY` = 1 and 15.
